serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around the existing single-bit full adder `fa_1bit`.
- Accepts two operands and a carry-in through a valid/ready handshake.
- Streams the operands LSB-first through one `fa_1bit` instance, one bit per clock, with a registered carry.
- Presents the WIDTH-bit sum, carry-out and signed overflow through a valid/ready output handshake.
- Sits directly downstream of operand sources and directly upstream of any result consumer. It is the sequential user of `fa_1bit`.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/fa_1bit.sv | 13 +
 rtl/serial_adder.sv | 93 +++++++++
 tb/tb_serial_adder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width; a floor of one bit keeps tiny widths legal.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_1bit.sv
// Single-bit full adder, reused as the arithmetic core of the serial adder.
module fa_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands stream LSB-first through one fa_1bit.
// state | meaning: IDLE accept operands; RUN one bit per clock; DONE hold result
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic [WIDTH-1:0]  sum_d;
  logic              carry_q;
  logic              cmsb_q;
  logic [CW-1:0]     cnt_q;
  logic              fa_sum;
  logic              fa_cout;

  fa_1bit u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  assign sum_d = {fa_sum, sum_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= in_cin;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= fa_cout;
          // carry_q here is the carry into the MSB; the counter parks at LAST.
          if (cnt_q == LAST) begin
            cmsb_q  <= carry_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;
  assign out_ovf   = cmsb_q ^ carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive bench for serial_adder at WIDTH=8 and WIDTH=4.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, cin8 = 1'b0, co8, ovf8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b0, cin4 = 1'b0, co4, ovf4;
  logic [3:0] a4 = '0, b4 = '0, s4;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_cin(cin8), .out_valid(ov8), .out_ready(or8), .out_sum(s8), .out_cout(co8),
    .out_ovf(ovf8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_cin(cin4), .out_valid(ov4), .out_ready(or4), .out_sum(s4), .out_cout(co4),
    .out_ovf(ovf4)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last4  = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer addition and the sign rule.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    logic [32:0] s;
    logic [32:0] mask;
    logic        ovf;
    s    = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    mask = (33'd1 << w) - 33'd1;
    ovf  = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ovf, s[w], 32'(s & mask)};
  endfunction

  // Transaction-level model: idle / busy for WIDTH cycles / holding a result.
  bit          mok = 1'b0;
  bit          m8_busy = 1'b0, m8_done = 1'b0, m4_busy = 1'b0, m4_done = 1'b0;
  int          m8_left = 0, m4_left = 0;
  logic [33:0] m8_res = '0, m4_res = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mok     <= 1'b1;
      m8_busy <= 1'b0; m8_done <= 1'b0; m8_res <= '0;
      m4_busy <= 1'b0; m4_done <= 1'b0; m4_res <= '0;
    end else begin
      if (m8_done) begin
        if (or8) m8_done <= 1'b0;
      end else if (m8_busy) begin
        m8_left <= m8_left - 1;
        if (m8_left == 1) begin m8_busy <= 1'b0; m8_done <= 1'b1; end
      end else if (iv8) begin
        m8_res <= ref_add(8, 32'(a8), 32'(b8), cin8);
        m8_busy <= 1'b1; m8_left <= 8;
      end
      if (m4_done) begin
        if (or4) m4_done <= 1'b0;
      end else if (m4_busy) begin
        m4_left <= m4_left - 1;
        if (m4_left == 1) begin m4_busy <= 1'b0; m4_done <= 1'b1; end
      end else if (iv4) begin
        m4_res <= ref_add(4, 32'(a4), 32'(b4), cin4);
        m4_busy <= 1'b1; m4_left <= 4;
      end
    end
  end

  always @(negedge clk) begin
    if (mok) begin
      chk("valid8", 32'(ov8), 32'(m8_done));
      chk("ready8", 32'(ir8), 32'(!(m8_busy || m8_done)));
      if (m8_done) begin
        chk("sum8",  32'(s8),   32'(m8_res[7:0]));
        chk("cout8", 32'(co8),  32'(m8_res[32]));
        chk("ovf8",  32'(ovf8), 32'(m8_res[33]));
      end
      chk("valid4", 32'(ov4), 32'(m4_done));
      chk("ready4", 32'(ir4), 32'(!(m4_busy || m4_done)));
      if (m4_done) begin
        chk("sum4",  32'(s4),   32'(m4_res[3:0]));
        chk("cout4", 32'(co4),  32'(m4_res[32]));
        chk("ovf4",  32'(ovf4), 32'(m4_res[33]));
      end
      if (iv4 && ir4 && !rst) begin
        if (last4 >= 0) chk("interval4", 32'((cyc - last4) >= 5), 32'd1);
        last4 <= cyc;
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] es, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; iv8 = 1'b1;
    n = 0;
    while (!ir8 && n < 30) begin @(negedge clk); n++; end
    chk("accept8", 32'(ir8), 32'd1);
    @(posedge clk); #1 iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 30) begin @(posedge clk); #1; n++; end
    chk("latency8", 32'(n), 32'd8);
    chk("lit_sum8",  32'(s8),   32'(es));
    chk("lit_cout8", 32'(co8),  32'(ec));
    chk("lit_ovf8",  32'(ovf8), 32'(eo));
  endtask

  task automatic rel8();
    @(negedge clk); or8 = 1'b1;
    @(posedge clk); #1 or8 = 1'b0;
    chk("rel_ready8", 32'(ir8), 32'd1);
    chk("rel_valid8", 32'(ov8), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready8", 32'(ir8), 32'd1);
    chk("rst_valid8", 32'(ov8), 32'd0);
    chk("rst_sum8",   32'(s8),  32'd0);
    chk("rst_cout8",  32'(co8), 32'd0);
    chk("rst_ovf8",   32'(ovf8), 32'd0);

    // out_ready with nothing pending must be harmless
    @(negedge clk); or8 = 1'b1;
    repeat (3) @(posedge clk);
    #1 or8 = 1'b0;
    chk("idle_ready8", 32'(ir8), 32'd1);

    op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0); rel8();
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0); rel8();
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1); rel8();
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0); rel8();
    op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv8 = ~iv8; a8 = 8'(8'h11 * (i + 1)); b8 = 8'(8'h05 * i); cin8 = i[0];
      @(posedge clk); #1;
      chk("bp_valid8", 32'(ov8), 32'd1);
      chk("bp_ready8", 32'(ir8), 32'd0);
      chk("bp_sum8",   32'(s8),  32'h00);
      chk("bp_cout8",  32'(co8), 32'd1);
    end
    @(negedge clk); iv8 = 1'b0;
    rel8();
    op8(8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 1'b0); rel8();

    // abort after three RUN cycles
    @(negedge clk); a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1 iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_valid8", 32'(ov8), 32'd0);
    chk("abort_ready8", 32'(ir8), 32'd1);
    chk("abort_sum8",   32'(s8),  32'd0);
    repeat (10) @(posedge clk);
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0); rel8();

    for (int k = 0; k < 512; k++) begin
      int n;
      int stall;
      stall = int'($urandom_range(0, 3));
      @(negedge clk);
      a4 = k[3:0]; b4 = k[7:4]; cin4 = k[8]; iv4 = 1'b1; or4 = (stall == 0);
      n = 0;
      while (!ir4 && n < 30) begin @(negedge clk); n++; end
      chk("accept4", 32'(ir4), 32'd1);
      @(posedge clk); #1 iv4 = 1'b0;
      n = 0;
      while (!ov4 && n < 30) begin @(posedge clk); #1; n++; end
      chk("latency4", 32'(n), 32'd4);
      if (stall == 0) begin
        @(posedge clk); #1 or4 = 1'b0;
      end else begin
        repeat (stall) @(posedge clk);
        @(negedge clk); or4 = 1'b1;
        @(posedge clk); #1 or4 = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
